// File: rtl/manual_entry_fsm.sv
// Operator-driven control source for data_path: debounced KEY presses step through
// opcode / destination / source capture, then issue one register-file write.

module manual_entry_key #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);
    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             deb;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            deb   <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 != deb) begin
                // The flip happens on the DEB_CYCLES-th consecutive disagreeing cycle
                if (cnt == CNT_LAST) begin
                    deb   <= sync2;
                    cnt   <= '0;
                    press <= ~sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module manual_entry_fsm #(
    parameter int unsigned DEB_CYCLES = 250000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_enter_n,
    input  logic        key_cancel_n,
    input  logic [9:0]  sw,
    input  logic [4:0]  Flags_in,
    output logic [3:0]  Rsrc_sel,
    output logic [3:0]  Rdest_sel,
    output logic        Imm_sel,
    output logic [15:0] Imm_in,
    output logic [7:0]  opcode,
    output logic [15:0] wEnable,
    output logic [4:0]  flags_q,
    output logic [3:0]  stage_led,
    output logic        done_pulse
);
    typedef enum logic [2:0] {S_OPC, S_DST, S_SRC, S_EXEC, S_DONE} state_t;

    state_t state;
    state_t state_nx;
    logic   enter_evt;
    logic   cancel_evt;
    logic   advance;
    logic   nowrite;

    manual_entry_key #(.DEB_CYCLES(DEB_CYCLES)) u_enter (
        .clk   (clk),
        .reset (reset),
        .key_n (key_enter_n),
        .press (enter_evt)
    );

    manual_entry_key #(.DEB_CYCLES(DEB_CYCLES)) u_cancel (
        .clk   (clk),
        .reset (reset),
        .key_n (key_cancel_n),
        .press (cancel_evt)
    );

    // Cancel takes priority over a coincident enter
    assign advance = enter_evt & ~cancel_evt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_OPC;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        wEnable    = '0;
        done_pulse = 1'b0;
        stage_led  = 4'b0000;
        case (state)
            S_OPC: begin
                stage_led = 4'b0001;
                if (advance) state_nx = S_DST;
            end
            S_DST: begin
                stage_led = 4'b0010;
                if (cancel_evt)   state_nx = S_OPC;
                else if (advance) state_nx = S_SRC;
            end
            S_SRC: begin
                stage_led = 4'b0100;
                if (cancel_evt)   state_nx = S_OPC;
                else if (advance) state_nx = S_EXEC;
            end
            S_EXEC: begin
                stage_led = 4'b1000;
                if (!nowrite) wEnable = 16'h0001 << Rdest_sel;
                state_nx = S_DONE;
            end
            S_DONE: begin
                stage_led  = 4'b1000;
                done_pulse = 1'b1;
                state_nx   = S_OPC;
            end
            default: state_nx = S_OPC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            opcode    <= '0;
            Rdest_sel <= '0;
            Rsrc_sel  <= '0;
            Imm_sel   <= 1'b0;
            Imm_in    <= '0;
            nowrite   <= 1'b0;
            flags_q   <= '0;
        end else begin
            if (advance && state == S_OPC) opcode <= sw[7:0];
            if (advance && state == S_DST) Rdest_sel <= sw[3:0];
            if (advance && state == S_SRC) begin
                nowrite <= sw[8];
                if (sw[9]) begin
                    Imm_sel <= 1'b1;
                    Imm_in  <= {{8{sw[7]}}, sw[7:0]};
                end else begin
                    Imm_sel  <= 1'b0;
                    Rsrc_sel <= sw[3:0];
                end
            end
            if (state == S_DONE) flags_q <= Flags_in;
        end
    end
endmodule

// File: tb/tb_manual_entry_fsm.sv
// Directed bench for manual_entry_fsm with DEB_CYCLES=4; expected values are hand-computed.

module tb_manual_entry_fsm;
    logic        clk;
    logic        reset;
    logic        key_enter_n;
    logic        key_cancel_n;
    logic [9:0]  sw;
    logic [4:0]  Flags_in;
    logic [3:0]  Rsrc_sel;
    logic [3:0]  Rdest_sel;
    logic        Imm_sel;
    logic [15:0] Imm_in;
    logic [7:0]  opcode;
    logic [15:0] wEnable;
    logic [4:0]  flags_q;
    logic [3:0]  stage_led;
    logic        done_pulse;

    int checks = 0;
    int errors = 0;
    int we_cycles = 0;
    int done_cnt = 0;
    logic [15:0] we_last = '0;
    int we_base;
    int done_base;

    manual_entry_fsm #(.DEB_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .key_enter_n  (key_enter_n),
        .key_cancel_n (key_cancel_n),
        .sw           (sw),
        .Flags_in     (Flags_in),
        .Rsrc_sel     (Rsrc_sel),
        .Rdest_sel    (Rdest_sel),
        .Imm_sel      (Imm_sel),
        .Imm_in       (Imm_in),
        .opcode       (opcode),
        .wEnable      (wEnable),
        .flags_q      (flags_q),
        .stage_led    (stage_led),
        .done_pulse   (done_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset && wEnable != 16'h0000) begin
            we_cycles = we_cycles + 1;
            we_last   = wEnable;
        end
        if (reset && done_pulse) done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_enter(input logic [9:0] v);
        sw = v;
        key_enter_n = 1'b0;
        tick(10);
        key_enter_n = 1'b1;
        tick(10);
    endtask

    task automatic press_cancel();
        key_cancel_n = 1'b0;
        tick(10);
        key_cancel_n = 1'b1;
        tick(10);
    endtask

    initial begin
        reset = 1'b0;
        key_enter_n = 1'b1;
        key_cancel_n = 1'b1;
        sw = '0;
        Flags_in = 5'h15;
        tick(3);
        check("rst_stage", 32'(stage_led), 32'h1);
        check("rst_opcode", 32'(opcode), 32'h0);
        check("rst_wen", 32'(wEnable), 32'h0);
        check("rst_flags", 32'(flags_q), 32'h0);
        check("rst_done", 32'(done_pulse), 32'h0);
        check("rst_imm", 32'(Imm_in), 32'h0);
        reset = 1'b1;
        tick(2);

        // Register-source write to R5
        press_enter(10'h012);
        check("w1_stage_dst", 32'(stage_led), 32'h2);
        check("w1_opcode", 32'(opcode), 32'h12);
        press_enter(10'h005);
        check("w1_stage_src", 32'(stage_led), 32'h4);
        check("w1_rdest", 32'(Rdest_sel), 32'h5);
        we_base = we_cycles;
        sw = 10'h003;
        key_enter_n = 1'b0;
        tick(7);
        check("w1_exec_stage", 32'(stage_led), 32'h8);
        check("w1_exec_wen", 32'(wEnable), 32'h0020);
        check("w1_rsrc", 32'(Rsrc_sel), 32'h3);
        check("w1_immsel", 32'(Imm_sel), 32'h0);
        tick(1);
        check("w1_done_wen", 32'(wEnable), 32'h0);
        check("w1_done_pulse", 32'(done_pulse), 32'h1);
        tick(1);
        check("w1_flags", 32'(flags_q), 32'h15);
        check("w1_done_clr", 32'(done_pulse), 32'h0);
        check("w1_stage_opc", 32'(stage_led), 32'h1);
        key_enter_n = 1'b1;
        tick(10);
        check("w1_we_cycles", 32'(we_cycles - we_base), 32'h1);

        // Immediate source, sign-extended, write to R15
        Flags_in = 5'h0A;
        we_base = we_cycles;
        done_base = done_cnt;
        press_enter(10'h0AA);
        press_enter(10'h00F);
        press_enter(10'h2F0);
        check("w2_immsel", 32'(Imm_sel), 32'h1);
        check("w2_imm", 32'(Imm_in), 32'hFFF0);
        check("w2_rsrc_kept", 32'(Rsrc_sel), 32'h3);
        check("w2_opcode", 32'(opcode), 32'hAA);
        check("w2_we_last", 32'(we_last), 32'h8000);
        check("w2_we_cycles", 32'(we_cycles - we_base), 32'h1);
        check("w2_done_cnt", 32'(done_cnt - done_base), 32'h1);
        check("w2_flags", 32'(flags_q), 32'h0A);
        check("w2_stage", 32'(stage_led), 32'h1);

        // No-write transaction still completes and latches flags
        Flags_in = 5'h07;
        we_base = we_cycles;
        done_base = done_cnt;
        press_enter(10'h001);
        press_enter(10'h002);
        press_enter(10'h300);
        check("nw_we_cycles", 32'(we_cycles - we_base), 32'h0);
        check("nw_done_cnt", 32'(done_cnt - done_base), 32'h1);
        check("nw_flags", 32'(flags_q), 32'h07);
        check("nw_imm", 32'(Imm_in), 32'h0);
        check("nw_stage", 32'(stage_led), 32'h1);

        // Debounce: short glitch ignored, long press gives one event at DEB_CYCLES+2
        key_enter_n = 1'b0;
        tick(3);
        key_enter_n = 1'b1;
        tick(10);
        check("glitch_stage", 32'(stage_led), 32'h1);
        key_enter_n = 1'b0;
        tick(6);
        check("deb_evt_at6", 32'(dut.enter_evt), 32'h1);
        check("deb_stage_at6", 32'(stage_led), 32'h1);
        tick(1);
        check("deb_stage_at7", 32'(stage_led), 32'h2);
        tick(93);
        check("deb_hold_stage", 32'(stage_led), 32'h2);
        key_enter_n = 1'b1;
        tick(10);
        check("deb_release_stage", 32'(stage_led), 32'h2);

        // Cancel from S_DST and S_SRC, then coincident enter+cancel in S_DST
        we_base = we_cycles;
        press_cancel();
        check("cx_dst_stage", 32'(stage_led), 32'h1);
        press_enter(10'h033);
        press_enter(10'h004);
        check("cx_pre_stage", 32'(stage_led), 32'h4);
        press_cancel();
        check("cx_src_stage", 32'(stage_led), 32'h1);
        check("cx_opcode_kept", 32'(opcode), 32'h33);
        press_enter(10'h044);
        check("cx_both_pre", 32'(stage_led), 32'h2);
        key_enter_n = 1'b0;
        key_cancel_n = 1'b0;
        tick(10);
        key_enter_n = 1'b1;
        key_cancel_n = 1'b1;
        tick(10);
        check("cx_both_stage", 32'(stage_led), 32'h1);
        check("cx_we_cycles", 32'(we_cycles - we_base), 32'h0);

        // Reset in S_SRC clears everything and no write follows
        press_enter(10'h055);
        press_enter(10'h009);
        check("rm_pre_stage", 32'(stage_led), 32'h4);
        we_base = we_cycles;
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        check("rm_stage", 32'(stage_led), 32'h1);
        check("rm_opcode", 32'(opcode), 32'h0);
        check("rm_rdest", 32'(Rdest_sel), 32'h0);
        check("rm_rsrc", 32'(Rsrc_sel), 32'h0);
        check("rm_immsel", 32'(Imm_sel), 32'h0);
        check("rm_imm", 32'(Imm_in), 32'h0);
        check("rm_flags", 32'(flags_q), 32'h0);
        tick(20);
        check("rm_after_stage", 32'(stage_led), 32'h1);
        check("rm_we_cycles", 32'(we_cycles - we_base), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
